// File: rtl/axi_mm_wr_arb2.sv
// Two-requester AXI write arbiter: round-robin AW grant into a one-entry slice, with a
// W-order FIFO steering write data by grant order and B routed back by m_bid[3].
module axi_mm_wr_arb2 #(
    parameter int unsigned ORD_DEPTH = 4
) (
    input  logic                       clk_wr,
    input  logic                       rst_wr_n,
    // requester 0
    input  logic [2:0]                 s0_awid,
    input  logic [2:0]                 s0_awsize,
    input  logic [7:0]                 s0_awlen,
    input  logic [1:0]                 s0_awburst,
    input  logic [31:0]                s0_awaddr,
    input  logic                       s0_awvalid,
    output logic                       s0_awready,
    input  logic [2:0]                 s0_wid,
    input  logic [127:0]               s0_wdata,
    input  logic [15:0]                s0_wstrb,
    input  logic                       s0_wlast,
    input  logic                       s0_wvalid,
    output logic                       s0_wready,
    output logic [2:0]                 s0_bid,
    output logic [1:0]                 s0_bresp,
    output logic                       s0_bvalid,
    input  logic                       s0_bready,
    // requester 1
    input  logic [2:0]                 s1_awid,
    input  logic [2:0]                 s1_awsize,
    input  logic [7:0]                 s1_awlen,
    input  logic [1:0]                 s1_awburst,
    input  logic [31:0]                s1_awaddr,
    input  logic                       s1_awvalid,
    output logic                       s1_awready,
    input  logic [2:0]                 s1_wid,
    input  logic [127:0]               s1_wdata,
    input  logic [15:0]                s1_wstrb,
    input  logic                       s1_wlast,
    input  logic                       s1_wvalid,
    output logic                       s1_wready,
    output logic [2:0]                 s1_bid,
    output logic [1:0]                 s1_bresp,
    output logic                       s1_bvalid,
    input  logic                       s1_bready,
    // downstream master
    output logic [3:0]                 m_awid,
    output logic [2:0]                 m_awsize,
    output logic [7:0]                 m_awlen,
    output logic [1:0]                 m_awburst,
    output logic [31:0]                m_awaddr,
    output logic                       m_awvalid,
    input  logic                       m_awready,
    output logic [3:0]                 m_wid,
    output logic [127:0]               m_wdata,
    output logic [15:0]                m_wstrb,
    output logic                       m_wlast,
    output logic                       m_wvalid,
    input  logic                       m_wready,
    input  logic [3:0]                 m_bid,
    input  logic [1:0]                 m_bresp,
    input  logic                       m_bvalid,
    output logic                       m_bready,
    output logic [$clog2(ORD_DEPTH):0] ord_count
);

    localparam int unsigned PTR_W = $clog2(ORD_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(ORD_DEPTH);

    typedef enum logic {SlEmpty, SlFull} sl_state_e;

    sl_state_e        r_sl_state;
    sl_state_e        w_sl_state_nxt;
    logic [3:0]       r_aw_id;
    logic [2:0]       r_aw_size;
    logic [7:0]       r_aw_len;
    logic [1:0]       r_aw_burst;
    logic [31:0]      r_aw_addr;
    logic             r_last_grant;
    logic             r_ord_mem [ORD_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_can_load;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_arb_en;
    logic w_pick1;
    logic w_grant;
    logic w_head;
    logic w_push;
    logic w_pop;

    // ---------------- AW arbitration ----------------
    always_comb begin
        w_can_load  = (r_sl_state == SlEmpty) || m_awready;
        w_fifo_full = (r_count == FULL_CNT);
        // Gated by reset so no awready pulse can escape while the block is held.
        w_arb_en    = rst_wr_n && w_can_load && !w_fifo_full;
        w_pick1     = (s0_awvalid && s1_awvalid) ? !r_last_grant : s1_awvalid;
        w_grant     = w_arb_en && (s0_awvalid || s1_awvalid);
        s0_awready  = w_grant && !w_pick1;
        s1_awready  = w_grant && w_pick1;
    end

    always_comb begin
        w_sl_state_nxt = r_sl_state;
        unique case (r_sl_state)
            SlEmpty: if (w_grant) w_sl_state_nxt = SlFull;
            SlFull:  if (m_awready && !w_grant) w_sl_state_nxt = SlEmpty;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_sl_state   <= SlEmpty;
            r_last_grant <= 1'b1;
            r_aw_id      <= '0;
            r_aw_size    <= '0;
            r_aw_len     <= '0;
            r_aw_burst   <= '0;
            r_aw_addr    <= '0;
        end else begin
            r_sl_state <= w_sl_state_nxt;
            if (w_grant) begin
                r_last_grant <= w_pick1;
                r_aw_id      <= {w_pick1, (w_pick1 ? s1_awid : s0_awid)};
                r_aw_size    <= w_pick1 ? s1_awsize  : s0_awsize;
                r_aw_len     <= w_pick1 ? s1_awlen   : s0_awlen;
                r_aw_burst   <= w_pick1 ? s1_awburst : s0_awburst;
                r_aw_addr    <= w_pick1 ? s1_awaddr  : s0_awaddr;
            end
        end
    end

    assign m_awvalid = (r_sl_state == SlFull);
    assign m_awid    = r_aw_id;
    assign m_awsize  = r_aw_size;
    assign m_awlen   = r_aw_len;
    assign m_awburst = r_aw_burst;
    assign m_awaddr  = r_aw_addr;

    // ---------------- W-order FIFO ----------------
    assign w_push = w_grant;
    assign w_pop  = m_wvalid && m_wready && m_wlast;

    always_ff @(posedge clk_wr) begin
        if (w_push) r_ord_mem[r_wr_ptr] <= w_pick1;
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign ord_count = r_count;

    // ---------------- W steering ----------------
    always_comb begin
        w_fifo_empty = (r_count == '0);
        w_head       = r_ord_mem[r_rd_ptr];
        m_wvalid     = !w_fifo_empty && (w_head ? s1_wvalid : s0_wvalid);
        m_wid        = {w_head, (w_head ? s1_wid : s0_wid)};
        m_wdata      = w_head ? s1_wdata : s0_wdata;
        m_wstrb      = w_head ? s1_wstrb : s0_wstrb;
        m_wlast      = w_head ? s1_wlast : s0_wlast;
        s0_wready    = !w_fifo_empty && !w_head && m_wready;
        s1_wready    = !w_fifo_empty && w_head && m_wready;
    end

    // ---------------- B routing ----------------
    always_comb begin
        s0_bvalid = m_bvalid && !m_bid[3];
        s1_bvalid = m_bvalid && m_bid[3];
        s0_bid    = m_bid[2:0];
        s1_bid    = m_bid[2:0];
        s0_bresp  = m_bresp;
        s1_bresp  = m_bresp;
        m_bready  = m_bid[3] ? s1_bready : s0_bready;
    end

endmodule

// File: tb/tb_axi_mm_wr_arb2.sv
// Bench for axi_mm_wr_arb2: directed scenarios plus a randomized run checked against a
// queue-based model of grant order, slice occupancy and W steering.
module tb_axi_mm_wr_arb2;

    localparam int unsigned DEPTH = 4;

    logic clk_wr = 1'b0;
    logic rst_wr_n;
    logic [2:0] s0_awid, s0_awsize, s1_awid, s1_awsize;
    logic [7:0] s0_awlen, s1_awlen;
    logic [1:0] s0_awburst, s1_awburst;
    logic [31:0] s0_awaddr, s1_awaddr;
    logic s0_awvalid, s0_awready, s1_awvalid, s1_awready;
    logic [2:0] s0_wid, s1_wid;
    logic [127:0] s0_wdata, s1_wdata;
    logic [15:0] s0_wstrb, s1_wstrb;
    logic s0_wlast, s0_wvalid, s0_wready, s1_wlast, s1_wvalid, s1_wready;
    logic [2:0] s0_bid, s1_bid;
    logic [1:0] s0_bresp, s1_bresp;
    logic s0_bvalid, s0_bready, s1_bvalid, s1_bready;
    logic [3:0] m_awid, m_wid, m_bid;
    logic [2:0] m_awsize;
    logic [7:0] m_awlen;
    logic [1:0] m_awburst, m_bresp;
    logic [31:0] m_awaddr;
    logic m_awvalid, m_awready;
    logic [127:0] m_wdata;
    logic [15:0] m_wstrb;
    logic m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [2:0] ord_count;

    int n_cmp = 0;
    int n_err = 0;

    axi_mm_wr_arb2 #(.ORD_DEPTH(DEPTH)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n),
        .s0_awid(s0_awid), .s0_awsize(s0_awsize), .s0_awlen(s0_awlen),
        .s0_awburst(s0_awburst), .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid),
        .s0_awready(s0_awready), .s0_wid(s0_wid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
        .s0_wlast(s0_wlast), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_bid(s0_bid),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_awid(s1_awid), .s1_awsize(s1_awsize), .s1_awlen(s1_awlen),
        .s1_awburst(s1_awburst), .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid),
        .s1_awready(s1_awready), .s1_wid(s1_wid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
        .s1_wlast(s1_wlast), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bid(s1_bid),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m_awid(m_awid), .m_awsize(m_awsize), .m_awlen(m_awlen), .m_awburst(m_awburst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .ord_count(ord_count)
    );

    always #5 clk_wr = ~clk_wr;

    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    task automatic idle_inputs();
        {s0_awid, s0_awsize, s0_awlen, s0_awburst, s0_awaddr, s0_awvalid} = '0;
        {s1_awid, s1_awsize, s1_awlen, s1_awburst, s1_awaddr, s1_awvalid} = '0;
        {s0_wid, s0_wdata, s0_wstrb, s0_wlast, s0_wvalid, s0_bready} = '0;
        {s1_wid, s1_wdata, s1_wstrb, s1_wlast, s1_wvalid, s1_bready} = '0;
        {m_awready, m_wready, m_bid, m_bresp, m_bvalid} = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_wr_n = 1'b0;
        tick();
        tick();
        rst_wr_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_wr_n = 1'b0;
        s0_awvalid = 1; s1_awvalid = 1; m_awready = 1; s0_wvalid = 1; s1_wvalid = 1;
        m_wready = 1; m_bvalid = 1; m_bid = 4'h3; m_bresp = 2'd1; s0_bready = 1;
        tick();
        tick();
        n_cmp++;
        if ({m_awvalid, s0_awready, s1_awready, s0_wready, s1_wready, m_wvalid} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {m_awvalid, s0_awready, s1_awready, s0_wready, s1_wready, m_wvalid});
        end
        n_cmp++;
        if (ord_count !== 3'd0) begin
            n_err++; $display("FAIL reset_ord_count: got %0d want 0", ord_count);
        end
        n_cmp++;
        if ({s0_bvalid, s0_bid, s0_bresp, s1_bvalid, m_bready} !== {1'b1, 3'd3, 2'd1, 1'b0, 1'b1})
        begin
            n_err++;
            $display("FAIL reset_b_comb: got %b want 1011010 1",
                     {s0_bvalid, s0_bid, s0_bresp, s1_bvalid, m_bready});
        end
    endtask

    task automatic test_tie();
        apply_reset();
        m_awready = 1;
        s0_awvalid = 1; s0_awid = 3'd5; s0_awaddr = 32'h1000;
        s1_awvalid = 1; s1_awid = 3'd3; s1_awaddr = 32'h2000;
        #1;
        n_cmp++;
        if ({s0_awready, s1_awready} !== 2'b10) begin
            n_err++; $display("FAIL tie_first: got %b want 10", {s0_awready, s1_awready});
        end
        tick();
        s0_awvalid = 0;
        #1;
        n_cmp++;
        if ({m_awvalid, m_awid, m_awaddr} !== {1'b1, 4'h5, 32'h1000}) begin
            n_err++; $display("FAIL tie_s0_slice: got %h want 1_5_00001000",
                              {m_awvalid, m_awid, m_awaddr});
        end
        n_cmp++;
        if ({s0_awready, s1_awready} !== 2'b01) begin
            n_err++; $display("FAIL tie_second: got %b want 01", {s0_awready, s1_awready});
        end
        tick();
        s1_awvalid = 0;
        #1;
        n_cmp++;
        if ({m_awvalid, m_awid, m_awaddr, ord_count} !== {1'b1, 4'hB, 32'h2000, 3'd2}) begin
            n_err++; $display("FAIL tie_s1_slice: got id=%h addr=%h cnt=%0d want B 2000 2",
                              m_awid, m_awaddr, ord_count);
        end
        tick();
        n_cmp++;
        if (m_awvalid !== 1'b0) begin
            n_err++; $display("FAIL tie_drain: got m_awvalid=%b want 0", m_awvalid);
        end
    endtask

    task automatic test_burst_order();
        logic [127:0] exp_data;
        apply_reset();
        m_awready = 1;
        s0_awvalid = 1; s0_awlen = 8'd3; s0_awid = 3'd1;
        tick();
        s0_awvalid = 0; s1_awvalid = 1; s1_awlen = 8'd0; s1_awid = 3'd6;
        tick();
        s1_awvalid = 0;
        n_cmp++;
        if ({m_awid, m_awlen, ord_count} !== {4'hE, 8'd0, 3'd2}) begin
            n_err++; $display("FAIL burst_aw: got id=%h len=%0d cnt=%0d want E 0 2",
                              m_awid, m_awlen, ord_count);
        end
        m_wready = 1; s0_wvalid = 1; s0_wid = 3'd1; s0_wstrb = 16'hFFFF;
        s1_wvalid = 1; s1_wid = 3'd6; s1_wdata = 128'hBB; s1_wstrb = 16'h00FF; s1_wlast = 1;
        for (int k = 0; k < 4; k++) begin
            exp_data = {96'd0, 32'hA0 + 32'(k)};
            s0_wdata = exp_data;
            s0_wlast = (k == 3);
            #1;
            n_cmp++;
            if ({m_wvalid, m_wid, m_wdata, m_wlast, s0_wready, s1_wready} !==
                {1'b1, 4'h1, exp_data, (k == 3), 2'b10}) begin
                n_err++; $display("FAIL burst_s0_beat%0d: got v=%b id=%h d=%h l=%b rdy=%b%b",
                                  k, m_wvalid, m_wid, m_wdata, m_wlast, s0_wready, s1_wready);
            end
            tick();
        end
        s0_wvalid = 0;
        #1;
        n_cmp++;
        if ({m_wvalid, m_wid, m_wdata, m_wlast, s0_wready, s1_wready} !==
            {1'b1, 4'hE, 128'hBB, 1'b1, 2'b01}) begin
            n_err++; $display("FAIL burst_s1_beat: got v=%b id=%h d=%h l=%b rdy=%b%b",
                              m_wvalid, m_wid, m_wdata, m_wlast, s0_wready, s1_wready);
        end
        tick();
        n_cmp++;
        if ({ord_count, m_wvalid, s1_wready} !== {3'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL burst_done: got cnt=%0d v=%b want 0 0", ord_count, m_wvalid);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        s0_awvalid = 1; s0_awid = 3'd2; s0_awaddr = 32'hA000;
        s1_awvalid = 1; s1_awid = 3'd4; s1_awaddr = 32'hB000;
        #1;
        n_cmp++;
        if ({s0_awready, s1_awready} !== 2'b10) begin
            n_err++; $display("FAIL bp_first: got %b want 10", {s0_awready, s1_awready});
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            s0_awaddr = $urandom; s1_awaddr = $urandom;
            #1;
            n_cmp++;
            if ({s0_awready, s1_awready, m_awvalid, m_awid, m_awaddr} !==
                {2'b00, 1'b1, 4'h2, 32'hA000}) begin
                n_err++; $display("FAIL bp_hold%0d: got rdy=%b%b v=%b id=%h a=%h", i,
                                  s0_awready, s1_awready, m_awvalid, m_awid, m_awaddr);
            end
            tick();
        end
        n_cmp++;
        if (ord_count !== 3'd1) begin
            n_err++; $display("FAIL bp_count: got %0d want 1", ord_count);
        end
        m_awready = 1;
        #1;
        n_cmp++;
        if ({s0_awready, s1_awready} !== 2'b01) begin
            n_err++; $display("FAIL bp_release: got %b want 01", {s0_awready, s1_awready});
        end
    endtask

    task automatic test_fifo_full();
        logic [1:0] exp_rdy;
        apply_reset();
        m_awready = 1; s0_awvalid = 1; s1_awvalid = 1;
        for (int i = 0; i < 4; i++) begin
            exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
            #1;
            n_cmp++;
            if ({s0_awready, s1_awready} !== exp_rdy) begin
                n_err++; $display("FAIL full_grant%0d: got %b want %b", i,
                                  {s0_awready, s1_awready}, exp_rdy);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({ord_count, s0_awready, s1_awready} !== {3'd4, 2'b00}) begin
                n_err++; $display("FAIL full_block%0d: got cnt=%0d rdy=%b%b want 4 00", i,
                                  ord_count, s0_awready, s1_awready);
            end
            tick();
        end
        s0_wvalid = 1; s0_wlast = 1; m_wready = 1;
        #1;
        n_cmp++;
        if ({s0_wready, s1_wready, s0_awready, s1_awready} !== 4'b1000) begin
            n_err++; $display("FAIL full_pop_cycle: got %b want 1000",
                              {s0_wready, s1_wready, s0_awready, s1_awready});
        end
        tick();
        s0_wvalid = 0; m_wready = 0;
        #1;
        n_cmp++;
        if ({ord_count, s0_awready, s1_awready} !== {3'd3, 2'b10}) begin
            n_err++; $display("FAIL full_regrant: got cnt=%0d rdy=%b%b want 3 10",
                              ord_count, s0_awready, s1_awready);
        end
        tick();
        n_cmp++;
        if ({ord_count, s0_awready, s1_awready} !== {3'd4, 2'b00}) begin
            n_err++; $display("FAIL full_again: got cnt=%0d rdy=%b%b want 4 00",
                              ord_count, s0_awready, s1_awready);
        end
    endtask

    task automatic test_b_routing();
        apply_reset();
        m_bvalid = 1; m_bid = 4'hA; m_bresp = 2'd2; s1_bready = 1; s0_bready = 0;
        #1;
        n_cmp++;
        if ({s1_bvalid, s1_bid, s1_bresp, s0_bvalid, m_bready} !==
            {1'b1, 3'd2, 2'd2, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL b_to_s1: got %b want 1010100 1",
                              {s1_bvalid, s1_bid, s1_bresp, s0_bvalid, m_bready});
        end
        s1_bready = 0; s0_bready = 1;
        #1;
        n_cmp++;
        if (m_bready !== 1'b0) begin
            n_err++; $display("FAIL b_ready_s1: got %b want 0", m_bready);
        end
        m_bid = 4'h5; m_bresp = 2'd1;
        #1;
        n_cmp++;
        if ({s0_bvalid, s0_bid, s0_bresp, s1_bvalid, m_bready} !==
            {1'b1, 3'd5, 2'd1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL b_to_s0: got %b want 1101010 1",
                              {s0_bvalid, s0_bid, s0_bresp, s1_bvalid, m_bready});
        end
        m_bvalid = 0;
        #1;
        n_cmp++;
        if ({s0_bvalid, s1_bvalid} !== 2'b00) begin
            n_err++; $display("FAIL b_idle: got %b want 00", {s0_bvalid, s1_bvalid});
        end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        m_awready = 1; s0_awvalid = 1; s1_awvalid = 1; s0_awid = 3'd7;
        tick();
        tick();
        s1_awvalid = 0;
        tick();
        s0_awvalid = 0; s0_wvalid = 1; s0_wlast = 0; m_wready = 1;
        #1;
        n_cmp++;
        if ({ord_count, m_wvalid} !== {3'd3, 1'b1}) begin
            n_err++; $display("FAIL mid_setup: got cnt=%0d v=%b want 3 1", ord_count, m_wvalid);
        end
        tick();
        s0_awvalid = 1; s1_awvalid = 1; m_bvalid = 1; m_bid = 4'h9;
        rst_wr_n = 0;
        #1;
        n_cmp++;
        if ({m_awvalid, s0_awready, s1_awready, s0_wready, s1_wready, m_wvalid, ord_count,
             s1_bvalid} !== {6'b0, 3'd0, 1'b1}) begin
            n_err++; $display("FAIL mid_reset: got v=%b rdy=%b%b%b%b wv=%b cnt=%0d b1=%b",
                              m_awvalid, s0_awready, s1_awready, s0_wready, s1_wready,
                              m_wvalid, ord_count, s1_bvalid);
        end
        tick();
        tick();
        rst_wr_n = 1; m_bvalid = 0;
        #1;
        n_cmp++;
        if ({s0_awready, s1_awready} !== 2'b10) begin
            n_err++; $display("FAIL mid_first_tie: got %b want 10", {s0_awready, s1_awready});
        end
        tick();
        n_cmp++;
        if ({m_awvalid, m_awid} !== {1'b1, 4'h7}) begin
            n_err++; $display("FAIL mid_regrant: got v=%b id=%h want 1 7", m_awvalid, m_awid);
        end
    endtask

    task automatic test_random();
        logic [48:0] slice_q[$];
        bit ord_q[$];
        bit last_g;
        int g;
        bit h, hv, hlast, pop;
        logic [1:0] exp_rdy;
        logic [48:0] new_pl;
        apply_reset();
        last_g = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s0_awvalid = 1'($urandom_range(0, 1)); s1_awvalid = 1'($urandom_range(0, 1));
            s0_awid = 3'($urandom); s0_awsize = 3'($urandom); s0_awlen = 8'($urandom);
            s0_awburst = 2'($urandom); s0_awaddr = $urandom;
            s1_awid = 3'($urandom); s1_awsize = 3'($urandom); s1_awlen = 8'($urandom);
            s1_awburst = 2'($urandom); s1_awaddr = $urandom;
            s0_wvalid = 1'($urandom_range(0, 1)); s1_wvalid = 1'($urandom_range(0, 1));
            s0_wid = 3'($urandom); s1_wid = 3'($urandom);
            s0_wdata = {$urandom, $urandom, $urandom, $urandom};
            s1_wdata = {$urandom, $urandom, $urandom, $urandom};
            s0_wstrb = 16'($urandom); s1_wstrb = 16'($urandom);
            s0_wlast = ($urandom_range(0, 3) == 0); s1_wlast = ($urandom_range(0, 3) == 0);
            m_awready = ($urandom_range(0, 3) != 0); m_wready = 1'($urandom_range(0, 1));
            #1;
            g = -1;
            if (((slice_q.size() == 0) || m_awready) && (ord_q.size() < DEPTH)) begin
                if (s0_awvalid && s1_awvalid) g = last_g ? 0 : 1;
                else if (s0_awvalid) g = 0;
                else if (s1_awvalid) g = 1;
            end
            exp_rdy = (g == 0) ? 2'b10 : (g == 1) ? 2'b01 : 2'b00;
            n_cmp++;
            if ({s0_awready, s1_awready} !== exp_rdy) begin
                n_err++; $display("FAIL rnd_awready@%0d: got %b want %b", cyc,
                                  {s0_awready, s1_awready}, exp_rdy);
            end
            n_cmp++;
            if (m_awvalid !== (slice_q.size() != 0) ||
                (slice_q.size() != 0 &&
                 {m_awid, m_awsize, m_awlen, m_awburst, m_awaddr} !== slice_q[0])) begin
                n_err++; $display("FAIL rnd_aw_slice@%0d: got v=%b id=%h a=%h, want %0d entries",
                                  cyc, m_awvalid, m_awid, m_awaddr, slice_q.size());
            end
            n_cmp++;
            if (ord_count !== 3'(ord_q.size())) begin
                n_err++; $display("FAIL rnd_ord_count@%0d: got %0d want %0d", cyc, ord_count,
                                  ord_q.size());
            end
            pop = 0;
            n_cmp++;
            if (ord_q.size() == 0) begin
                if ({m_wvalid, s0_wready, s1_wready} !== 3'b000) begin
                    n_err++; $display("FAIL rnd_w_empty@%0d: got %b want 000", cyc,
                                      {m_wvalid, s0_wready, s1_wready});
                end
            end else begin
                h = ord_q[0];
                hv = h ? s1_wvalid : s0_wvalid;
                hlast = h ? s1_wlast : s0_wlast;
                pop = hv && m_wready && hlast;
                if ({m_wvalid, m_wid, m_wdata, m_wstrb, m_wlast, s0_wready, s1_wready} !==
                    {hv, h, (h ? s1_wid : s0_wid), (h ? s1_wdata : s0_wdata),
                     (h ? s1_wstrb : s0_wstrb), hlast, (!h && m_wready), (h && m_wready)}) begin
                    n_err++; $display("FAIL rnd_w_route@%0d: head=%0d got v=%b id=%h l=%b rdy=%b%b",
                                      cyc, h, m_wvalid, m_wid, m_wlast, s0_wready, s1_wready);
                end
            end
            new_pl = (g == 1) ? {1'b1, s1_awid, s1_awsize, s1_awlen, s1_awburst, s1_awaddr}
                              : {1'b0, s0_awid, s0_awsize, s0_awlen, s0_awburst, s0_awaddr};
            tick();
            if (slice_q.size() != 0 && m_awready) void'(slice_q.pop_front());
            if (pop) void'(ord_q.pop_front());
            if (g >= 0) begin
                slice_q.push_back(new_pl);
                ord_q.push_back(g[0]);
                last_g = g[0];
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst_wr_n = 1'b0;
        test_reset();
        test_tie();
        test_burst_order();
        test_backpressure();
        test_fifo_full();
        test_b_routing();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
